// File: rtl/viterbi_pkg.sv
// Shared types and defaults for the Viterbi decoder frame sequencer.
package viterbi_pkg;

  localparam int unsigned FRAME_LEN_DEFAULT = 64;

  typedef logic [1:0] rx_pair_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HANDOFF,
    WAIT_TB
  } ctrl_state_e;

endpackage

// File: rtl/viterbi_tb_arbiter.sv
// Traceback hand-off: owns the ping-pong write bank, the tb_busy flag,
// the tb_start pulse and the frame counter.
module viterbi_tb_arbiter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             handoff_req,
  input  logic             tb_done,
  output logic             grant_c,
  output logic             wr_bank,
  output logic             tb_start,
  output logic             tb_bank,
  output logic             tb_busy,
  output logic [CNT_W-1:0] frame_cnt
);

  // A pending frame may go once traceback is idle or finishing this cycle.
  assign grant_c = handoff_req & (~tb_busy | tb_done);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_bank   <= 1'b0;
      tb_start  <= 1'b0;
      tb_bank   <= 1'b0;
      tb_busy   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      tb_start <= grant_c;
      // tb_done arriving with tb_start (or while idle) is deliberately lost.
      tb_busy  <= tb_start | (tb_busy & ~tb_done);
      if (grant_c) begin
        tb_bank   <= wr_bank;
        wr_bank   <= ~wr_bank;
        frame_cnt <= frame_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/viterbi_frame_ctrl.sv
// Viterbi frame sequencer: accepts symbol pairs, drives BMC/ACS/survivor
// memory writes and hands completed frames to traceback.
module viterbi_frame_ctrl
  import viterbi_pkg::*;
#(
  parameter int unsigned FRAME_LEN = FRAME_LEN_DEFAULT,
  parameter int unsigned ADDR_W    = $clog2(FRAME_LEN),
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              in_valid,
  output logic              in_ready,
  input  rx_pair_t          rx_pair_in,
  output rx_pair_t          bmc_rx_pair,
  output logic              acs_en,
  output logic              acs_init,
  output logic              sm_wr_en,
  output logic              sm_wr_bank,
  output logic [ADDR_W-1:0] sm_wr_addr,
  output logic              tb_start,
  output logic              tb_bank,
  input  logic              tb_done,
  output logic              tb_busy,
  output logic [CNT_W-1:0]  frame_cnt
);

  ctrl_state_e       state_q, state_d;
  logic [ADDR_W-1:0] step_q;
  logic              accept_c;
  logic              last_step_c;
  logic              handoff_req_c;
  logic              grant_c;
  logic              bank;

  assign accept_c    = in_valid & in_ready;
  assign last_step_c = (step_q == ADDR_W'(FRAME_LEN - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:             if (enable) state_d = RUN;
      RUN:              if (accept_c && last_step_c) state_d = HANDOFF;
      HANDOFF, WAIT_TB: state_d = grant_c ? RUN : WAIT_TB;
      default:          state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready      = 1'b0;
    handoff_req_c = 1'b0;
    case (state_q)
      RUN:              in_ready      = 1'b1;
      HANDOFF, WAIT_TB: handoff_req_c = 1'b1;
      default:          ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step_q <= '0;
    end else if (accept_c) begin
      step_q <= last_step_c ? '0 : step_q + ADDR_W'(1);
    end
  end

  // One-cycle datapath stage; the bank follows the live write bank so that it
  // only flips to the traceback bank's sibling, never onto it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bmc_rx_pair <= '0;
      acs_en      <= 1'b0;
      acs_init    <= 1'b0;
      sm_wr_en    <= 1'b0;
      sm_wr_bank  <= 1'b0;
      sm_wr_addr  <= '0;
    end else begin
      acs_en     <= accept_c;
      sm_wr_en   <= accept_c;
      acs_init   <= accept_c & (step_q == '0);
      sm_wr_bank <= bank;
      if (accept_c) begin
        bmc_rx_pair <= rx_pair_in;
        sm_wr_addr  <= step_q;
      end
    end
  end

  viterbi_tb_arbiter #(
    .CNT_W(CNT_W)
  ) u_arb (
    .clk        (clk),
    .rst        (rst),
    .handoff_req(handoff_req_c),
    .tb_done    (tb_done),
    .grant_c    (grant_c),
    .wr_bank    (bank),
    .tb_start   (tb_start),
    .tb_bank    (tb_bank),
    .tb_busy    (tb_busy),
    .frame_cnt  (frame_cnt)
  );

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// Randomized scoreboard bench for viterbi_frame_ctrl against a frame-level model.
module tb_viterbi_frame_ctrl;
  import viterbi_pkg::*;

  localparam int unsigned FL = 4;
  localparam int unsigned AW = 2;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          enable = 1'b0;
  logic          in_valid = 1'b0;
  logic          tb_done = 1'b0;
  rx_pair_t      rx_pair_in = '0;
  logic          in_ready, acs_en, acs_init, sm_wr_en, sm_wr_bank;
  logic          tb_start, tb_bank, tb_busy;
  rx_pair_t      bmc_rx_pair;
  logic [AW-1:0] sm_wr_addr;
  logic [CW-1:0] frame_cnt;

  always #5 clk = ~clk;

  viterbi_frame_ctrl #(.FRAME_LEN(FL), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid), .in_ready(in_ready),
    .rx_pair_in(rx_pair_in), .bmc_rx_pair(bmc_rx_pair), .acs_en(acs_en), .acs_init(acs_init),
    .sm_wr_en(sm_wr_en), .sm_wr_bank(sm_wr_bank), .sm_wr_addr(sm_wr_addr),
    .tb_start(tb_start), .tb_bank(tb_bank), .tb_done(tb_done), .tb_busy(tb_busy),
    .frame_cnt(frame_cnt)
  );

  typedef struct {
    rx_pair_t pair;
    int       addr;
    int       bank;
    bit       init;
  } wr_exp_t;

  typedef struct {
    int bank;
    int cnt;
  } tb_exp_t;

  wr_exp_t  wr_q[$];
  tb_exp_t  tb_q[$];
  int       n_cmp = 0;
  int       n_bad = 0;

  // Frame-level model: columns written so far, whether a full frame awaits
  // traceback, which bank is filling, and traceback ownership.
  bit       m_run, m_pending, m_busy, m_start;
  int       m_step, m_bank, m_cnt;
  rx_pair_t last_pair;

  function automatic void check(string name, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic model_reset();
    m_run = 0; m_pending = 0; m_busy = 0; m_start = 0;
    m_step = 0; m_bank = 0; m_cnt = 0;
    last_pair = '0;
    wr_q.delete();
    tb_q.delete();
  endtask

  task automatic check_reset_outputs();
    check("rst_in_ready", in_ready, 0);
    check("rst_bmc_rx_pair", bmc_rx_pair, 0);
    check("rst_acs_en", acs_en, 0);
    check("rst_acs_init", acs_init, 0);
    check("rst_sm_wr_en", sm_wr_en, 0);
    check("rst_sm_wr_bank", sm_wr_bank, 0);
    check("rst_sm_wr_addr", sm_wr_addr, 0);
    check("rst_tb_start", tb_start, 0);
    check("rst_tb_bank", tb_bank, 0);
    check("rst_tb_busy", tb_busy, 0);
    check("rst_frame_cnt", frame_cnt, 0);
  endtask

  // One clock: called just after a falling edge, returns at the next one.
  task automatic do_cycle(int valid_pct, int done_pct, bit en);
    bit ready, acc, grant;
    wr_exp_t w;
    tb_exp_t t;
    ready = m_run && !m_pending;
    check("in_ready", in_ready, ready);
    check("tb_busy", tb_busy, m_busy);
    check("tb_start_level", tb_start, m_start);
    check("frame_cnt_level", frame_cnt, m_cnt % (1 << CW));

    in_valid   = ($urandom_range(0, 99) < valid_pct);
    rx_pair_in = rx_pair_t'($urandom_range(0, 3));
    tb_done    = ($urandom_range(0, 99) < done_pct);
    enable     = en;

    acc   = ready && in_valid;
    grant = m_pending && (!m_busy || tb_done);
    m_busy  = m_start || (m_busy && !tb_done);
    m_start = grant;
    if (grant) begin
      m_cnt++;
      t.bank = m_bank;
      t.cnt  = m_cnt;
      tb_q.push_back(t);
      m_bank    = 1 - m_bank;
      m_pending = 0;
    end
    if (acc) begin
      w.pair = rx_pair_in;
      w.addr = m_step;
      w.bank = m_bank;
      w.init = (m_step == 0);
      wr_q.push_back(w);
      m_step++;
      if (m_step == FL) begin
        m_step    = 0;
        m_pending = 1;
      end
    end
    if (!m_run && enable) m_run = 1;
    @(negedge clk);
  endtask

  // Monitor: consumes expectations whenever the DUT presents a write or hand-off.
  initial begin
    wr_exp_t w;
    tb_exp_t t;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        check("sm_wr_en_vs_acs_en", sm_wr_en, acs_en);
        if (acs_en) begin
          if (wr_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_write: got acs_en=1 expected no write at %0t", $time);
          end else begin
            w = wr_q.pop_front();
            check("bmc_rx_pair", bmc_rx_pair, w.pair);
            check("sm_wr_addr", sm_wr_addr, w.addr);
            check("sm_wr_bank", sm_wr_bank, w.bank);
            check("acs_init", acs_init, w.init);
            last_pair = w.pair;
          end
        end else begin
          check("acs_init_gap", acs_init, 0);
          check("bmc_rx_pair_hold", bmc_rx_pair, last_pair);
        end
        if (tb_start) begin
          if (tb_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_tb_start: got tb_start=1 expected none at %0t", $time);
          end else begin
            t = tb_q.pop_front();
            check("tb_bank", tb_bank, t.bank);
            check("frame_cnt_handoff", frame_cnt, t.cnt % (1 << CW));
          end
        end
        if (tb_busy) check("bank_exclusive", sm_wr_bank == tb_bank, 0);
      end
    end
  end

  initial begin
    int guard;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs();
    rst = 1'b1;
    @(negedge clk);
    repeat (5) do_cycle(100, 0, 1'b0);
    repeat (300) do_cycle(100, 100, 1'b1);
    repeat (400) do_cycle(60, 5, $urandom_range(0, 1) == 1);
    repeat (400) do_cycle(90, 30, $urandom_range(0, 1) == 1);

    // Abort a frame two columns in.
    guard = 0;
    while (!(m_run && !m_pending && m_step == 2) && guard < 200) begin
      do_cycle(50, 20, 1'b1);
      guard++;
    end
    check("midframe_reached", guard < 200, 1);
    rst = 1'b0;
    #1;
    check_reset_outputs();
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (300) do_cycle(75, 15, 1'b1);
    repeat (30) do_cycle(0, 100, 1'b1);

    check("wr_queue_drained", wr_q.size(), 0);
    check("tb_queue_drained", tb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
